// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
  parameter int DATA_W = 16
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: variable-latency load/store via req/ack, stalling upstream while an access is open.
// Optional WAIT timeout with sticky mem_err is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exmem_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  memtoreg,
  input  logic                  reg_write,
  input  logic                  halt,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [REG_W-1:0]      instr_rd,
  mem_access_stage_if.master    dmem,
  output logic                  stall,
  output logic                  memtoreg_out,
  output logic                  reg_write_out,
  output logic                  halt_out,
  output logic [DATA_W-1:0]     read_data_out,
  output logic [DATA_W-1:0]     alu_out_out,
  output logic [REG_W-1:0]      instr_rd_out,
  output logic                  mem_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state_q;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_op;
  logic              timeout_hit;

  assign mem_op = exmem_valid & (mem_read | mem_write);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));
  assign mem_err     = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  // Default is a bubble; alu_out/instr_rd always pass through because they are don't-care in a bubble
  always_comb begin
    stall         = 1'b0;
    reg_write_out = 1'b0;
    memtoreg_out  = 1'b0;
    halt_out      = 1'b0;
    read_data_out = '0;
    alu_out_out   = alu_out;
    instr_rd_out  = instr_rd;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            stall = 1'b1;
          end else if (exmem_valid) begin
            reg_write_out = reg_write;
            memtoreg_out  = memtoreg;
            halt_out      = halt;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_ack) begin
            reg_write_out = reg_write;
            memtoreg_out  = memtoreg;
            halt_out      = halt;
            read_data_out = we_q ? '0 : dmem.dmem_rdata;
          end else if (timeout_hit) begin
            halt_out = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            we_q    <= mem_write;
            addr_q  <= alu_out;
            wdata_q <= write_data;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (dmem.dmem_ack || timeout_hit) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          if (!dmem.dmem_ack) begin
            if (timeout_hit) err_q <= 1'b1;
            else             cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of pass-through vectors plus load/store/reset/timeout sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        exmem_valid, mem_read, mem_write, memtoreg, reg_write, halt;
  logic [15:0] alu_out, write_data;
  logic [2:0]  instr_rd;
  logic        stall, memtoreg_out, reg_write_out, halt_out, mem_err;
  logic [15:0] read_data_out, alu_out_out;
  logic [2:0]  instr_rd_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage_if #(.DATA_W(16)) dif ();

  mem_access_stage #(.DATA_W(16), .REG_W(3), .TIMEOUT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .exmem_valid   (exmem_valid),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .memtoreg      (memtoreg),
    .reg_write     (reg_write),
    .halt          (halt),
    .alu_out       (alu_out),
    .write_data    (write_data),
    .instr_rd      (instr_rd),
    .dmem          (dif),
    .stall         (stall),
    .memtoreg_out  (memtoreg_out),
    .reg_write_out (reg_write_out),
    .halt_out      (halt_out),
    .read_data_out (read_data_out),
    .alu_out_out   (alu_out_out),
    .instr_rd_out  (instr_rd_out),
    .mem_err       (mem_err)
  );

  typedef struct {
    logic        rw;
    logic        m2r;
    logic        hlt;
    logic        stl;
    logic [15:0] rdata;
    logic [15:0] alu;
    logic [2:0]  rd;
    bit          chk_pass;
  } exp_t;

  typedef struct {
    logic        v;
    logic        rw;
    logic        m2r;
    logic        hlt;
    logic [15:0] alu;
    logic [2:0]  rd;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got no expected entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".stall"},     32'(stall),         32'(e.stl));
    check({tag, ".reg_write"}, 32'(reg_write_out), 32'(e.rw));
    check({tag, ".memtoreg"},  32'(memtoreg_out),  32'(e.m2r));
    check({tag, ".halt"},      32'(halt_out),      32'(e.hlt));
    check({tag, ".read_data"}, 32'(read_data_out), 32'(e.rdata));
    if (e.chk_pass) begin
      check({tag, ".alu_out"},  32'(alu_out_out),  32'(e.alu));
      check({tag, ".instr_rd"}, 32'(instr_rd_out), 32'(e.rd));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic mr, input logic mw, input logic m2r,
                       input logic rw, input logic h, input logic [15:0] alu,
                       input logic [15:0] wd, input logic [2:0] rd);
    exmem_valid = v;
    mem_read    = mr;
    mem_write   = mw;
    memtoreg    = m2r;
    reg_write   = rw;
    halt        = h;
    alu_out     = alu;
    write_data  = wd;
    instr_rd    = rd;
  endtask

  task automatic bubble;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{v:1'b0, rw:1'b1, m2r:1'b1, hlt:1'b1, alu:16'h1111, rd:3'd1,
               e:'{rw:1'b0, m2r:1'b0, hlt:1'b0, stl:1'b0, rdata:16'h0, alu:16'h0, rd:3'd0, chk_pass:1'b0}};
    tbl[1] = '{v:1'b1, rw:1'b1, m2r:1'b0, hlt:1'b0, alu:16'h1234, rd:3'd5,
               e:'{rw:1'b1, m2r:1'b0, hlt:1'b0, stl:1'b0, rdata:16'h0, alu:16'h1234, rd:3'd5, chk_pass:1'b1}};
    tbl[2] = '{v:1'b1, rw:1'b0, m2r:1'b0, hlt:1'b1, alu:16'h0000, rd:3'd0,
               e:'{rw:1'b0, m2r:1'b0, hlt:1'b1, stl:1'b0, rdata:16'h0, alu:16'h0000, rd:3'd0, chk_pass:1'b1}};
    tbl[3] = '{v:1'b1, rw:1'b1, m2r:1'b1, hlt:1'b0, alu:16'hFFFF, rd:3'd7,
               e:'{rw:1'b1, m2r:1'b1, hlt:1'b0, stl:1'b0, rdata:16'h0, alu:16'hFFFF, rd:3'd7, chk_pass:1'b1}};
    tbl[4] = '{v:1'b1, rw:1'b0, m2r:1'b0, hlt:1'b0, alu:16'h8000, rd:3'd2,
               e:'{rw:1'b0, m2r:1'b0, hlt:1'b0, stl:1'b0, rdata:16'h0, alu:16'h8000, rd:3'd2, chk_pass:1'b1}};

    // Reset held two cycles with a live ALU instruction present: outputs must stay bubbles
    reset          = 1'b1;
    dif.dmem_ack   = 1'b0;
    dif.dmem_rdata = 16'h0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 16'h0, 3'd6);
    @(negedge clk);
    check("rst.stall",     32'(stall),          32'd0);
    check("rst.reg_write", 32'(reg_write_out),  32'd0);
    check("rst.dmem_req",  32'(dif.dmem_req),   32'd0);
    check("rst.mem_err",   32'(mem_err),        32'd0);
    @(negedge clk);
    check("rst.dmem_addr", 32'(dif.dmem_addr),  32'd0);
    check("rst.dmem_we",   32'(dif.dmem_we),    32'd0);
    tick;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].v, 1'b0, 1'b0, tbl[i].m2r, tbl[i].rw, tbl[i].hlt, tbl[i].alu, 16'h0, tbl[i].rd);
      sb.push_back(tbl[i].e);
      @(negedge clk);
      sb_compare($sformatf("vec%0d", i));
      tick;
    end

    // Load acked after three stall cycles; halt rides along and must only appear on completion
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h0, 3'd3);
    @(negedge clk);
    check("ld.idle_stall",  32'(stall),         32'd1);
    check("ld.idle_rw",     32'(reg_write_out), 32'd0);
    check("ld.idle_halt",   32'(halt_out),      32'd0);
    check("ld.idle_req",    32'(dif.dmem_req),  32'd0);
    sb.push_back('{rw:1'b1, m2r:1'b1, hlt:1'b1, stl:1'b0, rdata:16'hBEEF, alu:16'h0040, rd:3'd3, chk_pass:1'b1});
    tick;
    @(negedge clk);
    check("ld.w1_stall", 32'(stall),         32'd1);
    check("ld.w1_req",   32'(dif.dmem_req),  32'd1);
    check("ld.w1_we",    32'(dif.dmem_we),   32'd0);
    check("ld.w1_addr",  32'(dif.dmem_addr), 32'h0040);
    tick;
    @(negedge clk);
    check("ld.w2_stall", 32'(stall),        32'd1);
    check("ld.w2_halt",  32'(halt_out),     32'd0);
    check("ld.w2_req",   32'(dif.dmem_req), 32'd1);
    tick;
    dif.dmem_ack   = 1'b1;
    dif.dmem_rdata = 16'hBEEF;
    @(negedge clk);
    sb_compare("load");
    tick;
    dif.dmem_ack = 1'b0;
    bubble();
    @(negedge clk);
    check("ld.after_req",   32'(dif.dmem_req), 32'd0);
    check("ld.after_stall", 32'(stall),        32'd0);
    tick;

    // Store with read also set (store wins); ack already high in IDLE must be ignored
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 16'h00A5, 3'd1);
    dif.dmem_ack   = 1'b1;
    dif.dmem_rdata = 16'h1111;
    @(negedge clk);
    check("st.idle_stall", 32'(stall),        32'd1);
    check("st.idle_req",   32'(dif.dmem_req), 32'd0);
    sb.push_back('{rw:1'b0, m2r:1'b0, hlt:1'b0, stl:1'b0, rdata:16'h0, alu:16'h0080, rd:3'd1, chk_pass:1'b1});
    tick;
    @(negedge clk);
    check("st.req",   32'(dif.dmem_req),   32'd1);
    check("st.we",    32'(dif.dmem_we),    32'd1);
    check("st.wdata", 32'(dif.dmem_wdata), 32'h00A5);
    check("st.addr",  32'(dif.dmem_addr),  32'h0080);
    sb_compare("store");
    tick;
    dif.dmem_ack = 1'b0;
    bubble();
    @(negedge clk);
    check("st.after_req", 32'(dif.dmem_req), 32'd0);
    check("st.after_we",  32'(dif.dmem_we),  32'd0);
    tick;

    // Reset in the second WAIT cycle abandons the access; a late ack must not commit anything
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0, 3'd2);
    @(negedge clk);
    check("rw.idle_stall", 32'(stall), 32'd1);
    tick;
    @(negedge clk);
    check("rw.w1_req", 32'(dif.dmem_req), 32'd1);
    tick;
    reset = 1'b1;
    @(negedge clk);
    check("rw.rst_stall", 32'(stall),         32'd0);
    check("rw.rst_rw",    32'(reg_write_out), 32'd0);
    tick;
    reset = 1'b0;
    bubble();
    dif.dmem_ack   = 1'b1;
    dif.dmem_rdata = 16'hDEAD;
    @(negedge clk);
    check("rw.late_req",   32'(dif.dmem_req),  32'd0);
    check("rw.late_stall", 32'(stall),         32'd0);
    check("rw.late_rw",    32'(reg_write_out), 32'd0);
    check("rw.late_rdata", 32'(read_data_out), 32'd0);
    tick;
    dif.dmem_ack = 1'b0;
    @(negedge clk);
    check("rw.idle_req", 32'(dif.dmem_req), 32'd0);
    tick;

    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0, 3'd4);
`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int  cnt;
      bit  done;
      cnt  = 0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        @(negedge clk);
        if (stall) begin
          cnt++;
          tick;
        end else begin
          done = 1'b1;
        end
      end
      check("to.stall_cycles", 32'(cnt),           32'd9);
      check("to.halt",         32'(halt_out),      32'd1);
      check("to.rw",           32'(reg_write_out), 32'd0);
      check("to.m2r",          32'(memtoreg_out),  32'd0);
      check("to.rdata",        32'(read_data_out), 32'd0);
      tick;
      bubble();
      @(negedge clk);
      check("to.err_set", 32'(mem_err),      32'd1);
      check("to.req",     32'(dif.dmem_req), 32'd0);
      tick;
      tick;
      tick;
      @(negedge clk);
      check("to.err_sticky", 32'(mem_err), 32'd1);
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      @(negedge clk);
      check("to.err_cleared", 32'(mem_err), 32'd0);
    end
`else
    begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (stall) cnt++;
        tick;
      end
      @(negedge clk);
      check("nt.stall_cycles", 32'(cnt),          32'd20);
      check("nt.still_stall",  32'(stall),        32'd1);
      check("nt.req",          32'(dif.dmem_req), 32'd1);
      check("nt.mem_err",      32'(mem_err),      32'd0);
      sb.push_back('{rw:1'b1, m2r:1'b1, hlt:1'b0, stl:1'b0, rdata:16'h5A5A, alu:16'h0200, rd:3'd4, chk_pass:1'b1});
      tick;
      dif.dmem_ack   = 1'b1;
      dif.dmem_rdata = 16'h5A5A;
      @(negedge clk);
      sb_compare("long_load");
      tick;
      dif.dmem_ack = 1'b0;
      bubble();
      @(negedge clk);
      check("nt.after_req", 32'(dif.dmem_req), 32'd0);
    end
`endif

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 16-bit pipeline, between the EX/MEM register and the MEM/WB register.
- Performs the data-memory load/store through a req/ack handshake that tolerates variable latency.
- Stalls the upstream pipeline while an access is outstanding.
- Its outputs feed the MEM/WB register directly: memtoreg, reg_write, read_data, alu_out, instr_rd, halt.

Parameters:
- DATA_W, 16, data/address width
- REG_W, 3, register specifier width
- TIMEOUT, 8, maximum WAIT cycles without ack (used only with MEM_ACCESS_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- exmem_valid  in  1  EX/MEM holds a real instruction
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- memtoreg  in  1  writeback selects memory data
- reg_write  in  1  instruction writes the register file
- halt  in  1  halt instruction marker
- alu_out  in  DATA_W  ALU result / memory address
- write_data  in  DATA_W  store data
- instr_rd  in  REG_W  destination register
- dmem_req  out  1  memory request (registered)
- dmem_we  out  1  request is a write (registered)
- dmem_addr  out  DATA_W  latched address
- dmem_wdata  out  DATA_W  latched store data
- dmem_ack  in  1  access complete this cycle
- dmem_rdata  in  DATA_W  load data, valid with ack
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- memtoreg_out, reg_write_out, halt_out  out  1 each  to MEM/WB
- read_data_out, alu_out_out  out  DATA_W each  to MEM/WB
- instr_rd_out  out  REG_W  to MEM/WB
- mem_err  out  1  sticky timeout flag

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (reset). Reset is sampled on posedge clk; there is no asynchronous path.
- mem_op = exmem_valid & (mem_read | mem_write). mem_write has priority if both are set: the access is a store.
- FSM states: IDLE, WAIT. Reset state: IDLE, with dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, mem_err=0.
- IDLE, exmem_valid=0: bubble outputs (reg_write_out=0, memtoreg_out=0, halt_out=0), stall=0.
- IDLE, valid and not mem_op: all inputs pass through combinationally, stall=0, read_data_out=0.
- IDLE, mem_op:
  - stall=1, bubble outputs.
  - On the clock edge: latch dmem_addr=alu_out and dmem_wdata=write_data, set dmem_we=mem_write, set dmem_req=1, go to WAIT.
- WAIT, dmem_ack=0: stall=1, bubble outputs; dmem_req and address/data held stable.
- WAIT, dmem_ack=1:
  - stall=0; control and alu_out/instr_rd pass through from the (held) inputs.
  - read_data_out = dmem_rdata for a load, 0 for a store.
  - On the clock edge: dmem_req=0, dmem_we=0, go to IDLE.
- Timing:
  - Minimum memory-op latency is 2 cycles (1 stall cycle).
  - Back-to-back memory ops each incur one IDLE stall cycle; dmem_req drops for at least one cycle between them.
- Upstream contract: EX/MEM inputs stay stable while stall=1.
- dmem_ack in IDLE is ignored.
- Reset while in WAIT: the access is abandoned. Next state is IDLE with dmem_req=0; a late ack is ignored.
- During reset cycles, outputs are forced to bubble values and stall=0.
- halt on a memory instruction propagates only in the completing cycle.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter resets on entry to WAIT.
  - If the counter reaches TIMEOUT with no ack: stall=0, reg_write_out=0, memtoreg_out=0, halt_out=1, read_data_out=0; mem_err is set and stays high until reset; dmem_req drops; the FSM returns to IDLE.
- Undefined: no counter; WAIT lasts indefinitely; mem_err is tied 0.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> dmem_req=0, stall=0, reg_write_out=0, mem_err=0.
- ALU pass-through: valid, reg_write=1, alu_out=0x1234, instr_rd=5, no mem op -> same cycle reg_write_out=1, alu_out_out=0x1234, instr_rd_out=5, stall=0.
- Load with 3-cycle ack: mem_read, alu_out=0x0040 -> stall=1 for 3 cycles, dmem_addr=0x0040; ack with rdata=0xBEEF -> read_data_out=0xBEEF, memtoreg_out=1, stall=0; dmem_req=0 next cycle.
- Store with immediate ack: mem_write, write_data=0x00A5 -> next cycle dmem_req=1, dmem_we=1, dmem_wdata=0x00A5; ack in the same cycle -> one stall cycle total, reg_write_out=0.
- Reset in WAIT: assert reset in the 2nd WAIT cycle, then pulse ack -> IDLE, dmem_req=0, no output commit.
- Timeout (macro defined, TIMEOUT=8): load never acked -> stall high for 9 cycles (IDLE + 8 WAIT), then halt_out=1, mem_err=1 sticky, reg_write_out=0.
